// File: rtl/core_reset_pkg.sv
// Shared types and reset-value constants for the core reset sequencer.
package core_reset_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        REL_VID = 2'd1,
        REL_AUD = 2'd2,
        RUN     = 2'd3
    } state_t;

    localparam logic        RST_ASSERTED = 1'b1;
    localparam logic [31:0] CFG_RESET    = 32'h0000_0000;
    localparam logic [7:0]  COUNT_RESET  = 8'd0;
    localparam logic [7:0]  COUNT_MAX    = 8'd255;

endpackage

// File: rtl/synch_3.sv
// Three-flop synchroniser for bringing asynchronous levels into the local clock domain.
module synch_3 #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_s0;
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s0 <= '0;
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s0 <= i_d;
            r_s1 <= r_s0;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/core_reset_seq.sv
// Staged reset sequencer: waits for stable DIP settings and PLL lock, then releases
// video, audio and CPU resets in turn and freezes the DIP snapshot for the game.
module core_reset_seq #(
    parameter int HOLD_CYCLES = 4096,
    parameter int STAGE_GAP   = 64
) (
    input  logic        clk_sync,
    input  logic        reset_n,
    input  logic        reset_sw,
    input  logic        pll_locked,
    input  logic [31:0] cfg_in,
    output logic [31:0] cfg_out,
    output logic        rst_video,
    output logic        rst_audio,
    output logic        rst_cpu,
    output logic        busy,
    output logic [7:0]  reset_count
);

    import core_reset_pkg::*;

    localparam int MAX_CYC = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);

    logic          w_lock_s;
    logic          w_abort;
    logic          w_cfg_chg;
    logic          w_seq_done;
    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [31:0]   r_cfg_prev;
    logic          w_rst_video_d;
    logic          w_rst_audio_d;
    logic          w_rst_cpu_d;
    logic          w_busy_d;

    synch_3 #(.WIDTH(1)) u_lock_sync (
        .i_clk   (clk_sync),
        .i_rst_n (reset_n),
        .i_d     (pll_locked),
        .o_q     (w_lock_s)
    );

    assign w_abort   = reset_sw | ~w_lock_s;
    assign w_cfg_chg = (cfg_in != r_cfg_prev);

    always_ff @(posedge clk_sync or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= HOLD;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_seq_done   = 1'b0;
        case (r_state)
            HOLD: begin
                if (w_abort || w_cfg_chg) begin
                    w_cnt_next = '0;
                end else if (r_cnt == HOLD_LAST) begin
                    w_cnt_next   = '0;
                    w_next_state = REL_VID;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            REL_VID, REL_AUD: begin
                // Abort wins over a terminal count landing in the same cycle.
                if (w_abort) begin
                    w_cnt_next   = '0;
                    w_next_state = HOLD;
                end else if (r_cnt == GAP_LAST) begin
                    w_cnt_next = '0;
                    if (r_state == REL_VID) begin
                        w_next_state = REL_AUD;
                    end else begin
                        w_next_state = RUN;
                        w_seq_done   = 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            RUN: begin
                if (w_abort) begin
                    w_cnt_next   = '0;
                    w_next_state = HOLD;
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_next_state = HOLD;
            end
        endcase
    end

    // Reset outputs decode the next state and are registered, so they never glitch.
    always_comb begin
        w_rst_video_d = (w_next_state == HOLD);
        w_rst_audio_d = (w_next_state == HOLD) || (w_next_state == REL_VID);
        w_rst_cpu_d   = (w_next_state != RUN);
        w_busy_d      = (w_next_state != RUN);
    end

    always_ff @(posedge clk_sync or negedge reset_n) begin
        if (!reset_n) begin
            r_cfg_prev  <= CFG_RESET;
            cfg_out     <= CFG_RESET;
            rst_video   <= RST_ASSERTED;
            rst_audio   <= RST_ASSERTED;
            rst_cpu     <= RST_ASSERTED;
            busy        <= 1'b1;
            reset_count <= COUNT_RESET;
        end else begin
            r_cfg_prev <= cfg_in;
            if (r_state == HOLD) begin
                cfg_out <= cfg_in;
            end
            rst_video <= w_rst_video_d;
            rst_audio <= w_rst_audio_d;
            rst_cpu   <= w_rst_cpu_d;
            busy      <= w_busy_d;
            if (w_seq_done && (reset_count != COUNT_MAX)) begin
                reset_count <= reset_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_core_reset_seq.sv
// Directed self-checking bench for core_reset_seq with HOLD_CYCLES=16, STAGE_GAP=4.
module tb_core_reset_seq;

    logic        clk_sync;
    logic        reset_n;
    logic        reset_sw;
    logic        pll_locked;
    logic [31:0] cfg_in;
    logic [31:0] cfg_out;
    logic        rst_video;
    logic        rst_audio;
    logic        rst_cpu;
    logic        busy;
    logic [7:0]  reset_count;

    int total = 0;
    int bad   = 0;

    core_reset_seq #(
        .HOLD_CYCLES (16),
        .STAGE_GAP   (4)
    ) dut (
        .clk_sync    (clk_sync),
        .reset_n     (reset_n),
        .reset_sw    (reset_sw),
        .pll_locked  (pll_locked),
        .cfg_in      (cfg_in),
        .cfg_out     (cfg_out),
        .rst_video   (rst_video),
        .rst_audio   (rst_audio),
        .rst_cpu     (rst_cpu),
        .busy        (busy),
        .reset_count (reset_count)
    );

    initial clk_sync = 1'b0;
    always #5 clk_sync = ~clk_sync;

    // Advance n rising edges, then park on the falling edge for sampling/driving.
    task automatic step(input int n);
        repeat (n) @(posedge clk_sync);
        @(negedge clk_sync);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Resets packed as {video, audio, cpu, busy}.
    task automatic check_rst(input string tag, input logic [3:0] exp);
        check(tag, {28'd0, rst_video, rst_audio, rst_cpu, busy}, {28'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n    = 1'b0;
        reset_sw   = 1'b0;
        pll_locked = 1'b1;
        cfg_in     = 32'hA5A5_0F0F;
        step(2);
        check_rst("por_rst", 4'b1111);
        check("por_cnt", {24'd0, reset_count}, 32'd0);
        check("por_cfg", cfg_out, 32'h0);

        // Power-up release: edge 0 is the last edge under reset.
        reset_n = 1'b1;
        step(18);
        check_rst("pu_e18", 4'b1111);
        step(1);
        check_rst("pu_e19", 4'b0111);
        step(3);
        check_rst("pu_e22", 4'b0111);
        step(1);
        check_rst("pu_e23", 4'b0011);
        step(3);
        check_rst("pu_e26", 4'b0011);
        step(1);
        check_rst("pu_e27", 4'b0000);
        check("pu_cnt", {24'd0, reset_count}, 32'd1);
        check("pu_cfg", cfg_out, 32'hA5A5_0F0F);

        // DIP change while running is ignored.
        cfg_in = 32'h0000_0001;
        step(5);
        check("run_cfg_frozen", cfg_out, 32'hA5A5_0F0F);
        check_rst("run_cfg_rst", 4'b0000);

        // One-cycle reset_sw pulse in RUN.
        reset_sw = 1'b1;
        step(1);
        reset_sw = 1'b0;
        check_rst("sw_hit", 4'b1111);
        step(15);
        check_rst("sw_e15", 4'b1111);
        step(1);
        check_rst("sw_e16", 4'b0111);
        step(4);
        check_rst("sw_e20", 4'b0011);
        step(3);
        check_rst("sw_e23", 4'b0011);
        step(1);
        check_rst("sw_e24", 4'b0000);
        check("sw_cnt", {24'd0, reset_count}, 32'd2);
        check("sw_cfg", cfg_out, 32'h0000_0001);

        // Toggling DIPs in HOLD keeps the sequence from releasing.
        reset_sw = 1'b1;
        step(1);
        reset_sw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cfg_in = 32'h0000_0100 + i;
            step(10);
            check_rst("tog_hold", 4'b1111);
        end
        step(6);
        check_rst("tog_e16", 4'b1111);
        step(1);
        check_rst("tog_e17", 4'b0111);
        step(4);
        check_rst("tog_aud", 4'b0011);

        // PLL drop in REL_AUD: abort lands on the same edge as terminal count.
        pll_locked = 1'b0;
        step(3);
        check_rst("pll_e3", 4'b0011);
        step(1);
        check_rst("pll_e4", 4'b1111);
        check("pll_cnt", {24'd0, reset_count}, 32'd2);
        step(5);
        check_rst("pll_hold", 4'b1111);
        check("pll_cfg", cfg_out, 32'h0000_0103);

        // Relock, then assert reset_n in the middle of REL_VID.
        pll_locked = 1'b1;
        step(18);
        check_rst("relock_e18", 4'b1111);
        step(1);
        check_rst("relock_e19", 4'b0111);
        step(2);
        #2;
        reset_n = 1'b0;
        #1;
        check_rst("rn_rst", 4'b1111);
        check("rn_cnt", {24'd0, reset_count}, 32'd0);
        check("rn_cfg", cfg_out, 32'h0);
        @(negedge clk_sync);
        reset_n = 1'b1;

        // Counter saturation over 300 completed sequences.
        step(27);
        check_rst("sat_first", 4'b0000);
        check("sat_1", {24'd0, reset_count}, 32'd1);
        for (int i = 0; i < 253; i++) begin
            reset_sw = 1'b1;
            step(1);
            reset_sw = 1'b0;
            step(24);
        end
        check("sat_254", {24'd0, reset_count}, 32'd254);
        for (int i = 0; i < 46; i++) begin
            reset_sw = 1'b1;
            step(1);
            reset_sw = 1'b0;
            step(24);
        end
        check("sat_255", {24'd0, reset_count}, 32'd255);
        check_rst("sat_run", 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
